dmem_arbiter: RTL and testbench

Two-master arbiter for the read/write port (port 0) of the data memory. It shares that single port between the CPU (master 0) and a secondary master (master 1), such as a DMA or UART loader. Arbitration is round-robin, with optional locked bursts bounded by `MAX_BURST`. The block sits between the masters and the memory: it muxes address, write data and write enable toward memory, and returns read data to the granted master. Memory read stays combinational; memory write stays synchronous.

---
 rtl/dmem_arbiter.sv | 71 +++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-master arbiter for data memory port 0 with bounded locked bursts
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int MAX_BURST = 16,
    parameter bit CPU_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wd,
    input  logic [31:0] m1_wd,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_rd,
    output logic [31:0] m1_rd,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    localparam int BW = $clog2(MAX_BURST);
    localparam logic [BW-1:0] TOP = BW'(MAX_BURST - 1);
    // one-hot owner states so each grant is a flop bit
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
    state_t state, nxt, other;
    logic last, last_nxt, own0, own1, req_x, req_y, lock_x;
    logic [BW-1:0] beats, beats_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            beats <= '0;
            last  <= CPU_FIRST;
        end else begin
            state <= nxt;
            beats <= beats_nxt;
            last  <= last_nxt;
        end
    end
    assign own0   = state[0];
    assign own1   = state[1];
    assign req_x  = own0 ? m0_req : m1_req;
    assign req_y  = own0 ? m1_req : m0_req;
    assign lock_x = own0 ? m0_lock : m1_lock;
    assign other  = own0 ? OWN1 : OWN0;
    always_comb begin
        nxt = state;
        if (state == IDLE)
            nxt = (m0_req && m1_req) ? (last ? OWN0 : OWN1) : m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
        else if (req_y && !(req_x && lock_x && beats != TOP))
            nxt = other;
        else if (!req_x)
            nxt = IDLE;
    end
    assign last_nxt  = (state != IDLE && nxt != state) ? own1 : last;
    assign beats_nxt = (nxt != state) ? '0 :
                       (state != IDLE && req_x && lock_x && beats != TOP) ? beats + 1'b1 : beats;
    assign m0_gnt   = own0;
    assign m1_gnt   = own1;
    assign mem_addr = own0 ? m0_addr : own1 ? m1_addr : '0;
    assign mem_wd   = own0 ? m0_wd : own1 ? m1_wd : '0;
    assign mem_we   = ~reset & (own0 ? (m0_we & m0_req) : (own1 & m1_we & m1_req));
    assign m0_rd    = own0 ? mem_rd : '0;
    assign m1_rd    = own1 ? mem_rd : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level arbiter model
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int MB = 4;
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] req = '0, lock = '0, we = '0, gnt;
    logic [31:0] addr [2], wd [2], rd [2];
    logic mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [31:0] mem [64], refm [64];
    logic pl_en = 1'b0;
    logic [5:0] pl_a = '0;
    logic [31:0] pl_d = '0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(MB), .CPU_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m1_req(req[1]), .m0_lock(lock[0]), .m1_lock(lock[1]),
        .m0_we(we[0]), .m1_we(we[1]), .m0_addr(addr[0]), .m1_addr(addr[1]),
        .m0_wd(wd[0]), .m1_wd(wd[1]), .m0_gnt(gnt[0]), .m1_gnt(gnt[1]),
        .m0_rd(rd[0]), .m1_rd(rd[1]), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // word-addressed memory: combinational read, synchronous write
    assign mem_rd = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
    end

    task automatic idle_inputs();
        req = '0; lock = '0; we = '0;
        addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pl_a = a[5:0]; pl_d = d; pl_en = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic test_reset();
        preload(0, 32'h1234_5678);
        reset = 1'b1; req = 2'b11; we = 2'b11; addr[0] = 32'h10; addr[1] = 32'h20;
        @(posedge clk);
        @(negedge clk);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_hold_gnt: got %b want 00", gnt); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_hold_we: got %b want 0", mem_we); end
        do_reset();
        @(negedge clk);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        total++; if (mem_wd !== 32'h0) begin bad++; $display("FAIL rst_wd: got %h want 0", mem_wd); end
        total++; if (rd[0] !== 32'h0 || rd[1] !== 32'h0) begin bad++; $display("FAIL rst_rd: got %h %h want 0 0", rd[0], rd[1]); end
    endtask

    task automatic test_single_read();
        do_reset();
        preload(4, 32'hDEAD_BEEF);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        @(negedge clk);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rd_early_gnt: got %b want 00", gnt); end
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rd_gnt: got %b want 01", gnt); end
        total++; if (rd[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rd[0]); end
        total++; if (rd[1] !== 32'h0) begin bad++; $display("FAIL rd_other: got %h want 0", rd[1]); end
        @(posedge clk);
        #1 req[0] = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        req = 2'b11; we = 2'b11;
        addr[0] = 32'h0; wd[0] = 32'h11; addr[1] = 32'h4; wd[1] = 32'h22;
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL cont_first: got %b want 01", gnt); end
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL cont_mem0: got we=%b a=%h want 1 0", mem_we, mem_addr); end
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL cont_second: got %b want 10", gnt); end
        total++; if (mem_addr !== 32'h4 || mem_wd !== 32'h22) begin bad++; $display("FAIL cont_mem1: got a=%h d=%h want 4 22", mem_addr, mem_wd); end
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        total++; if (mem[0] !== 32'h11 || mem[1] !== 32'h22) begin bad++; $display("FAIL cont_words: got %h %h want 11 22", mem[0], mem[1]); end
    endtask

    task automatic test_locked_burst();
        int n1 = 0;
        bit seen0 = 1'b0, gap = 1'b0, g1;
        do_reset();
        req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0; wd[1] = 32'h100;
        @(posedge clk);
        #1 req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40;
        for (int i = 0; i < 20 && !seen0; i++) begin
            @(negedge clk);
            g1 = gnt[1];
            total++; if (gnt === 2'b11) begin bad++; $display("FAIL burst_both: got %b", gnt); end
            if (g1) n1++;
            else if (gnt[0]) seen0 = 1'b1;
            else gap = 1'b1;
            @(posedge clk);
            #1;
            if (g1) begin addr[1] += 4; wd[1] += 1; end
        end
        req = '0; lock = '0;
        total++; if (n1 != MB) begin bad++; $display("FAIL burst_beats: got %0d want %0d", n1, MB); end
        total++; if (!seen0 || gap) begin bad++; $display("FAIL burst_handover: got seen0=%0d gap=%0d want 1 0", seen0, gap); end
        for (int i = 0; i < MB; i++) begin
            total++; if (mem[i] !== 32'h100 + 32'(i)) begin bad++; $display("FAIL burst_word%0d: got %h want %h", i, mem[i], 32'h100 + 32'(i)); end
        end
    endtask

    task automatic test_uncontended_burst();
        int n = 0, n2 = 0;
        bit seen0 = 1'b0, g1;
        do_reset();
        req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h80; wd[1] = 32'h200;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g1 = gnt[1];
            if (g1) n++;
            @(posedge clk);
            #1;
            if (g1) begin addr[1] += 4; wd[1] += 1; end
        end
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
        total++; if (n != 10) begin bad++; $display("FAIL ubur_beats: got %0d want 10", n); end
        total++; if (mem[41] !== 32'h209) begin bad++; $display("FAIL ubur_word: got %h want 209", mem[41]); end
        // counter is saturated, so one more locked beat is all m1 gets once m0 shows up
        for (int i = 0; i < 8 && !seen0; i++) begin
            @(negedge clk);
            g1 = gnt[1];
            if (g1) n2++;
            else if (gnt[0]) seen0 = 1'b1;
            @(posedge clk);
            #1;
            if (g1) begin addr[1] += 4; wd[1] += 1; end
        end
        req = '0; lock = '0;
        total++; if (n2 != 1 || !seen0) begin bad++; $display("FAIL ubur_sat: got extra=%0d seen0=%0d want 1 1", n2, seen0); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        preload(2, 32'h5555_5555);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wd[0] = 32'hBAD0_BAD0;
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 2'b01 || mem_we !== 1'b1) begin bad++; $display("FAIL rmw_pre: got gnt=%b we=%b want 01 1", gnt, mem_we); end
        reset = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmw_we: got %b want 0", mem_we); end
        @(posedge clk);
        #1 reset = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rmw_gnt: got %b want 00", gnt); end
        total++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin bad++; $display("FAIL rmw_mem: got %b %h %h want 0 0 0", mem_we, mem_addr, mem_wd); end
        total++; if (mem[2] !== 32'h5555_5555) begin bad++; $display("FAIL rmw_word: got %h want 55555555", mem[2]); end
    endtask

    task automatic test_park_release();
        int held = 0;
        do_reset();
        req[0] = 1'b1; addr[0] = 32'h10;
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL park_gnt: got %b want 01", gnt); end
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL park_idle: got %b want 00", gnt); end
        @(posedge clk);
        #1 req[0] = 1'b1;
        @(negedge clk);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL park_relat: got %b want 00", gnt); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (gnt === 2'b01) held++;
        end
        total++; if (held != 5) begin bad++; $display("FAIL park_hold: got %0d want 5", held); end
        req[0] = 1'b0;
    endtask

    task automatic test_random();
        int owner = -1, nown, run = 0, y;
        bit lst = 1'b1, o, done [2];
        logic [1:0] eg;
        logic ewe;
        logic [31:0] ea, ew, er0, er1;
        do_reset();
        for (int i = 0; i < 64; i++) refm[i] = mem[i];
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            o   = (owner == 1);
            eg  = owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00;
            ea  = owner >= 0 ? addr[o] : 32'h0;
            ew  = owner >= 0 ? wd[o] : 32'h0;
            ewe = owner >= 0 && req[o] && we[o];
            er0 = owner == 0 ? mem[addr[0][7:2]] : 32'h0;
            er1 = owner == 1 ? mem[addr[1][7:2]] : 32'h0;
            total++; if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt c=%0d: got %b want %b", c, gnt, eg); end
            total++; if (mem_we !== ewe) begin bad++; $display("FAIL rnd_we c=%0d: got %b want %b", c, mem_we, ewe); end
            total++; if (mem_addr !== ea) begin bad++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, mem_addr, ea); end
            total++; if (mem_wd !== ew) begin bad++; $display("FAIL rnd_wd c=%0d: got %h want %h", c, mem_wd, ew); end
            total++; if (rd[0] !== er0) begin bad++; $display("FAIL rnd_rd0 c=%0d: got %h want %h", c, rd[0], er0); end
            total++; if (rd[1] !== er1) begin bad++; $display("FAIL rnd_rd1 c=%0d: got %h want %h", c, rd[1], er1); end
            @(posedge clk);
            done[0] = (owner == 0) && req[0];
            done[1] = (owner == 1) && req[1];
            if (owner >= 0 && req[o] && we[o]) refm[addr[o][7:2]] = wd[o];
            nown = owner;
            if (owner < 0) begin
                nown = req == 2'b11 ? (lst ? 0 : 1) : req[0] ? 0 : req[1] ? 1 : -1;
            end else begin
                y = 1 - owner;
                // owner keeps the port unless the rival waits and no unexpired lock protects it
                if (req[o] && (!req[y] || (lock[o] && run < MB - 1))) begin
                    if (lock[o] && run < MB - 1) run++;
                end else begin
                    lst = o;
                    nown = req[y] ? y : -1;
                    run = 0;
                end
            end
            owner = nown;
            #1;
            for (int x = 0; x < 2; x++) begin
                if (!req[x] || done[x]) begin
                    req[x]  = ($urandom % 3) != 0;
                    lock[x] = ($urandom % 4) != 0;
                    we[x]   = $urandom % 2;
                    addr[x] = 32'($urandom_range(0, 63)) << 2;
                    wd[x]   = $urandom;
                end else if (owner != x && ($urandom % 16) == 0) begin
                    req[x] = 1'b0;
                end
            end
        end
        req = '0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            total++; if (mem[i] !== refm[i]) begin bad++; $display("FAIL rnd_word%0d: got %h want %h", i, mem[i], refm[i]); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_locked_burst();
        test_uncontended_burst();
        test_reset_mid_write();
        test_park_release();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
